// File: rtl/power_switch_ack_emu.sv
// Behavioural power-switch model: per-domain ramp FSM that turns switch_n requests into
// delayed ack_n responses, with abort pulses, busy status and a saturating power-off count.
module power_switch_ack_emu #(
  parameter int NUM_DOMAINS = 2,
  parameter int ON_LATENCY  = 16,
  parameter int OFF_LATENCY = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] switch_n_i,
  output logic [NUM_DOMAINS-1:0] ack_n_o,
  output logic [NUM_DOMAINS-1:0] busy_o,
  output logic [NUM_DOMAINS-1:0] abort_o,
  output logic [CNT_W-1:0]       off_count_o
);

  localparam int MAX_LAT = (ON_LATENCY > OFF_LATENCY) ? ON_LATENCY : OFF_LATENCY;
  localparam int RAMP_W  = $clog2(MAX_LAT) + 1;
  // The entry edge already counts as the first ramp edge, so only L-1 edges remain.
  localparam logic [RAMP_W-1:0] ON_LOAD  = RAMP_W'(ON_LATENCY - 1);
  localparam logic [RAMP_W-1:0] OFF_LOAD = RAMP_W'(OFF_LATENCY - 1);

  if (ON_LATENCY < 1 || ON_LATENCY > 1023 || OFF_LATENCY < 1 || OFF_LATENCY > 1023) begin : g_bad_latency
    $error("power_switch_ack_emu: ON_LATENCY/OFF_LATENCY must be within 1..1023");
  end

  typedef enum logic [1:0] {
    ST_ON,
    ST_RAMP_DOWN,
    ST_OFF,
    ST_RAMP_UP
  } state_e;

  state_e                 state_q [NUM_DOMAINS];
  state_e                 state_d [NUM_DOMAINS];
  logic [RAMP_W-1:0]      ramp_q  [NUM_DOMAINS];
  logic [RAMP_W-1:0]      ramp_d  [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] ack_n_q, ack_n_d;
  logic [NUM_DOMAINS-1:0] busy_q, busy_d;
  logic [NUM_DOMAINS-1:0] abort_q, abort_d;
  logic [NUM_DOMAINS-1:0] off_done;
  logic [CNT_W-1:0]       off_count_q, off_count_d;

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      state_d[i]  = state_q[i];
      ramp_d[i]   = ramp_q[i];
      ack_n_d[i]  = ack_n_q[i];
      busy_d[i]   = busy_q[i];
      abort_d[i]  = 1'b0;
      off_done[i] = 1'b0;
      case (state_q[i])
        ST_ON: begin
          if (switch_n_i[i]) begin
            if (OFF_LATENCY == 1) begin
              state_d[i]  = ST_OFF;
              ack_n_d[i]  = 1'b1;
              off_done[i] = 1'b1;
            end else begin
              state_d[i] = ST_RAMP_DOWN;
              ramp_d[i]  = OFF_LOAD;
              busy_d[i]  = 1'b1;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (!switch_n_i[i]) begin
            abort_d[i] = 1'b1;
            if (ON_LATENCY == 1) begin
              state_d[i] = ST_ON;
              busy_d[i]  = 1'b0;
            end else begin
              state_d[i] = ST_RAMP_UP;
              ramp_d[i]  = ON_LOAD;
            end
          end else if (ramp_q[i] == RAMP_W'(1)) begin
            state_d[i]  = ST_OFF;
            ack_n_d[i]  = 1'b1;
            busy_d[i]   = 1'b0;
            off_done[i] = 1'b1;
          end else begin
            ramp_d[i] = ramp_q[i] - RAMP_W'(1);
          end
        end
        ST_OFF: begin
          if (!switch_n_i[i]) begin
            if (ON_LATENCY == 1) begin
              state_d[i] = ST_ON;
              ack_n_d[i] = 1'b0;
            end else begin
              state_d[i] = ST_RAMP_UP;
              ramp_d[i]  = ON_LOAD;
              busy_d[i]  = 1'b1;
            end
          end
        end
        ST_RAMP_UP: begin
          if (switch_n_i[i]) begin
            abort_d[i] = 1'b1;
            if (OFF_LATENCY == 1) begin
              state_d[i]  = ST_OFF;
              ack_n_d[i]  = 1'b1;
              busy_d[i]   = 1'b0;
              off_done[i] = 1'b1;
            end else begin
              state_d[i] = ST_RAMP_DOWN;
              ramp_d[i]  = OFF_LOAD;
            end
          end else if (ramp_q[i] == RAMP_W'(1)) begin
            state_d[i] = ST_ON;
            ack_n_d[i] = 1'b0;
            busy_d[i]  = 1'b0;
          end else begin
            ramp_d[i] = ramp_q[i] - RAMP_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_ON;
        end
      endcase
    end
  end

  // Add one per completing domain, stopping at all-ones so the count never wraps.
  always_comb begin
    off_count_d = off_count_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (off_done[i] && (off_count_d != {CNT_W{1'b1}})) begin
        off_count_d = off_count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= ST_ON;
        ramp_q[i]  <= '0;
      end
      ack_n_q     <= '0;
      busy_q      <= '0;
      abort_q     <= '0;
      off_count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        state_q[i] <= state_d[i];
        ramp_q[i]  <= ramp_d[i];
      end
      ack_n_q     <= ack_n_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
      off_count_q <= off_count_d;
    end
  end

  assign ack_n_o     = ack_n_q;
  assign busy_o      = busy_q;
  assign abort_o     = abort_q;
  assign off_count_o = off_count_q;

  a_switch_known: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(switch_n_i));

endmodule

// File: tb/tb_power_switch_ack_emu.sv
// Directed bench for power_switch_ack_emu: default, asymmetric-latency and narrow-counter
// instances share one clock and reset; expected values are hand-computed per step.
module tb_power_switch_ack_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sw_a, sw_b, sw_c;
  logic [1:0]  ack_a, busy_a, abort_a;
  logic [1:0]  ack_b, busy_b, abort_b;
  logic [1:0]  ack_c, busy_c, abort_c;
  logic [15:0] count_a, count_b;
  logic [1:0]  count_c;

  int compare_count = 0;
  int fail_count    = 0;

  always #5 clk = ~clk;

  power_switch_ack_emu u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_a),
    .ack_n_o(ack_a), .busy_o(busy_a), .abort_o(abort_a), .off_count_o(count_a)
  );

  power_switch_ack_emu #(.ON_LATENCY(4), .OFF_LATENCY(20)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_b),
    .ack_n_o(ack_b), .busy_o(busy_b), .abort_o(abort_b), .off_count_o(count_b)
  );

  power_switch_ack_emu #(.ON_LATENCY(3), .OFF_LATENCY(3), .CNT_W(2)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_c),
    .ack_n_o(ack_c), .busy_o(busy_c), .abort_o(abort_c), .off_count_o(count_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    sw_a = a;
    sw_b = b;
    sw_c = c;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sw_a = 2'b00;
    sw_b = 2'b00;
    sw_c = 2'b00;
    #1;
    checkOutput("reset_ack", 32'(ack_a), 32'h0);
    checkOutput("reset_busy", 32'(busy_a), 32'h0);
    checkOutput("reset_abort", 32'(abort_a), 32'h0);
    checkOutput("reset_count", 32'(count_a), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] idle for 100 cycles");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00);
      checkOutput("idle_all", 32'({ack_a, busy_a, abort_a, count_a}), 32'h0);
    end

    $display("[TB] power-down domain 0, 16/16");
    applyStimulus(2'b01, 2'b00, 2'b00);
    checkOutput("pd_busy_entry", 32'(busy_a), 32'h1);
    checkOutput("pd_ack_entry", 32'(ack_a), 32'h0);
    for (int i = 2; i <= 15; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00);
      checkOutput("pd_ack_ramp", 32'(ack_a), 32'h0);
      checkOutput("pd_busy_ramp", 32'(busy_a), 32'h1);
    end
    applyStimulus(2'b01, 2'b00, 2'b00);
    checkOutput("pd_ack_done", 32'(ack_a), 32'h1);
    checkOutput("pd_busy_done", 32'(busy_a), 32'h0);
    checkOutput("pd_count_done", 32'(count_a), 32'h1);
    checkOutput("pd_abort_none", 32'(abort_a), 32'h0);

    $display("[TB] power-up domain 0");
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("pu_busy_entry", 32'(busy_a), 32'h1);
    checkOutput("pu_ack_entry", 32'(ack_a), 32'h1);
    for (int i = 2; i <= 15; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00);
      checkOutput("pu_ack_ramp", 32'(ack_a), 32'h1);
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("pu_ack_done", 32'(ack_a), 32'h0);
    checkOutput("pu_busy_done", 32'(busy_a), 32'h0);
    checkOutput("pu_count_same", 32'(count_a), 32'h1);

    $display("[TB] abort on domain 0");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00);
      checkOutput("ab_ack_down", 32'(ack_a), 32'h0);
      checkOutput("ab_abort_down", 32'(abort_a), 32'h0);
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("ab_abort_pulse", 32'(abort_a), 32'h1);
    checkOutput("ab_busy_rev", 32'(busy_a), 32'h1);
    checkOutput("ab_ack_rev", 32'(ack_a), 32'h0);
    for (int i = 1; i <= 14; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00);
      checkOutput("ab_abort_gone", 32'(abort_a), 32'h0);
      checkOutput("ab_busy_up", 32'(busy_a), 32'h1);
      checkOutput("ab_ack_up", 32'(ack_a), 32'h0);
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("ab_busy_clear", 32'(busy_a), 32'h0);
    checkOutput("ab_ack_final", 32'(ack_a), 32'h0);
    checkOutput("ab_count_same", 32'(count_a), 32'h1);

    $display("[TB] asymmetric 4/20 on domain 1");
    applyStimulus(2'b00, 2'b10, 2'b00);
    checkOutput("as_busy_entry", 32'(busy_b), 32'h2);
    for (int i = 2; i <= 19; i++) begin
      applyStimulus(2'b00, 2'b10, 2'b00);
      checkOutput("as_ack_down", 32'(ack_b), 32'h0);
      checkOutput("as_abort_down", 32'(abort_b), 32'h0);
    end
    applyStimulus(2'b00, 2'b10, 2'b00);
    checkOutput("as_ack_off", 32'(ack_b), 32'h2);
    checkOutput("as_busy_off", 32'(busy_b), 32'h0);
    checkOutput("as_count", 32'(count_b), 32'h1);
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("as_busy_up", 32'(busy_b), 32'h2);
    for (int i = 2; i <= 3; i++) begin
      applyStimulus(2'b00, 2'b00, 2'b00);
      checkOutput("as_ack_up", 32'(ack_b), 32'h2);
      checkOutput("as_abort_up", 32'(abort_b), 32'h0);
    end
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("as_ack_on", 32'(ack_b), 32'h0);
    checkOutput("as_busy_on", 32'(busy_b), 32'h0);

    $display("[TB] simultaneous power-off with 2-bit counter");
    applyStimulus(2'b00, 2'b00, 2'b11);
    applyStimulus(2'b00, 2'b00, 2'b11);
    checkOutput("sat_count_pre", 32'(count_c), 32'h0);
    applyStimulus(2'b00, 2'b00, 2'b11);
    checkOutput("sat_ack_off1", 32'(ack_c), 32'h3);
    checkOutput("sat_count_2", 32'(count_c), 32'h2);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("sat_ack_on1", 32'(ack_c), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 2'b11);
    checkOutput("sat_count_3", 32'(count_c), 32'h3);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 2'b00, 2'b11);
    checkOutput("sat_ack_off3", 32'(ack_c), 32'h3);
    checkOutput("sat_count_hold", 32'(count_c), 32'h3);

    $display("[TB] reset mid-ramp");
    for (int i = 0; i < 8; i++) applyStimulus(2'b01, 2'b00, 2'b00);
    checkOutput("rm_busy_before", 32'(busy_a), 32'h1);
    rst_n = 1'b0;
    #2;
    checkOutput("rm_async_all", 32'({ack_a, busy_a, abort_a, count_a}), 32'h0);
    rst_n = 1'b1;
    applyStimulus(2'b01, 2'b00, 2'b00);
    checkOutput("rm_busy_entry", 32'(busy_a), 32'h1);
    for (int i = 2; i <= 15; i++) begin
      applyStimulus(2'b01, 2'b00, 2'b00);
      checkOutput("rm_ack_ramp", 32'(ack_a), 32'h0);
    end
    applyStimulus(2'b01, 2'b00, 2'b00);
    checkOutput("rm_ack_done", 32'(ack_a), 32'h1);
    checkOutput("rm_count_done", 32'(count_a), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule

// File: doc/power_switch_ack_emu.md
Name: power_switch_ack_emu

Overview:
- Behavioural model of the on-chip power switches. It sits directly upstream of heepsilon_top's powergate ack inputs.
- It consumes the per-domain *_powergate_switch_no requests and returns the matching *_powergate_switch_ack_ni after a configurable ramp latency.
- It supports separate power-up and power-down latencies, aborted ramps and per-domain status, which lets benches stress the power manager beyond a fixed delay line.

Parameters:
- NUM_DOMAINS, 2, number of independent switch channels (bit 0 = cpu subsystem, bit 1 = peripheral subsystem).
- ON_LATENCY, 16, rising clock edges from a power-on request (switch_n 1->0) until ack_n reaches 0. Range 1..1023.
- OFF_LATENCY, 16, rising clock edges from a power-off request (switch_n 0->1) until ack_n reaches 1. Range 1..1023.
- CNT_W, 16, width of the completed-power-off counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- switch_n_i  input  NUM_DOMAINS  switch request per domain: 0 = power on, 1 = power off.
- ack_n_o  output  NUM_DOMAINS  switch acknowledge per domain: 0 = powered, 1 = unpowered.
- busy_o  output  NUM_DOMAINS  1 while the domain is ramping.
- abort_o  output  NUM_DOMAINS  one-cycle pulse when a ramp is reversed before completion.
- off_count_o  output  CNT_W  completed power-off transitions summed over all domains, saturating.

Behaviour:
- Reset: all channels in ON, ack_n_o = 0, busy_o = 0, abort_o = 0, off_count_o = 0. Counters are cleared.
- Reset assertion mid-ramp immediately forces the reset values; the ramp is discarded.
- One FSM per channel. States: ON, RAMP_DOWN, OFF, RAMP_UP.
- Ramp counter per channel, width clog2(max(ON_LATENCY, OFF_LATENCY)) + 1.
- ON:
  - Stays while switch_n_i = 0.
  - When switch_n_i = 1 at an edge: if OFF_LATENCY = 1, go directly to OFF with ack_n_o = 1 at that edge. Otherwise go to RAMP_DOWN, busy_o = 1.
- RAMP_DOWN:
  - ack_n_o holds 0.
  - If switch_n_i stays 1, ack_n_o becomes 1 and the state becomes OFF exactly at the OFF_LATENCY-th rising edge that sampled switch_n_i = 1, counting the first as 1.
  - On that same edge busy_o -> 0 and off_count_o increments by 1.
  - If switch_n_i = 0 at any edge before completion: go to RAMP_UP, counter reloads for a full ON_LATENCY, abort_o pulses 1 for one cycle.
- OFF / RAMP_UP: symmetric to ON / RAMP_DOWN.
  - ack_n_o becomes 0 at the ON_LATENCY-th edge sampling switch_n_i = 0.
  - Reversal during RAMP_UP goes to RAMP_DOWN with a full OFF_LATENCY reload and an abort pulse.
  - No off_count increment on this path.
- ack_n_o always reflects the last completed state, never the in-progress request. It changes only on completion edges.
- Timing equivalence: with ON_LATENCY = OFF_LATENCY = L and no aborts, ack_n_o equals switch_n_i delayed by L registers.
- Channels are fully independent. Simultaneous completion on several channels in one cycle increments off_count_o by the number of channels completing power-off, saturating at 2^CNT_W - 1.
- Saturation: off_count_o holds at all-ones and never wraps.
- busy_o is registered, asserted on the edge that enters a RAMP state and cleared on the completion edge.
- abort_o is registered and high for exactly one cycle per reversal.
- A request glitch that reverts before being sampled is invisible.
- Simulation assertions:
  - Error on X/Z in switch_n_i after reset release.
  - Elaboration error if either latency parameter is outside 1..1023.

Test Plan:
- Reset/idle: release rst_ni with switch_n_i = 2'b00 for 100 cycles -> ack_n_o = 00, busy_o = 00, abort_o = 00, off_count_o = 0 throughout.
- Power-down: defaults (16/16), switch_n_i[0] 0->1 sampled at edge k -> busy_o[0] = 1 from edge k, ack_n_o[0] = 1 exactly at edge k+15, off_count_o = 1, ack_n_o[1] unchanged at 0.
- Asymmetric latency: ON_LATENCY = 4, OFF_LATENCY = 20, full off/on cycle on domain 1 -> ack_n_o[1] rises 20 edges after request, falls 4 edges after release, abort_o never asserted.
- Abort: switch_n_i[0] = 1 for 5 cycles then back to 0 -> abort_o[0] pulses once at the reversal edge, ack_n_o[0] stays 0 throughout, busy_o[0] clears 16 edges after reversal, off_count_o unchanged.
- Simultaneous/saturation: CNT_W = 2, both domains power off on the same edge twice -> off_count_o goes 0 -> 2 -> 3 and stays 3.
- Reset mid-ramp: assert rst_ni low at ramp cycle 8 of a power-down -> outputs return to reset values asynchronously (before the next edge); after release, a fresh request takes a full 16 edges.
